game_over_overlay: RTL

Pixel-pipeline stage placed directly upstream and downstream of the Game Over sprite frame RAM. It takes the VGA scan position and background colour, generates the sprite RAM read address, and absorbs the RAM's one-cycle registered read latency. It then composites the returned sprite pixel over the background. A frame-synchronous state machine shows, blinks, and hides the overlay according to the game-over condition.

---
 rtl/game_over_overlay.sv | 226 ++++++++++++++++++++++
 1 files changed

// File: rtl/game_over_overlay.sv
// game_over_overlay
// -----------------------------------------------------------------------------
// Pixel-pipeline stage wrapped around the Game Over sprite frame RAM.
//   Stage 1: hit test against the sprite rectangle, RAM read address, and
//            capture of background colour / valid / show for this pixel.
//   Stage 2: the RAM registers its read data; side-band bits advance with it.
//   Stage 3: composite the sprite pixel over the background (black is the
//            transparent key) and register the result.
// A frame-synchronous FSM (IDLE -> WAIT_FRAME -> SHOW) decides when the
// overlay is shown, so that it only ever appears or disappears on a frame
// boundary.
//
// Optional feature macro: GAMEOVER_BLINK_EN
//   defined   : the sprite blinks, BLINK_FRAMES frames on / BLINK_FRAMES off.
//   undefined : the sprite is steady for the whole SHOW period.
// -----------------------------------------------------------------------------
module game_over_overlay #(
    parameter int SPRITE_W     = 128,  // sprite width in pixels
    parameter int SPRITE_H     = 64,   // sprite height in pixels
    parameter int ORIGIN_X     = 256,  // screen X of the sprite's top-left pixel
    parameter int ORIGIN_Y     = 208,  // screen Y of the sprite's top-left pixel
    parameter int BLINK_FRAMES = 30    // frames per blink phase, 1..63
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic        frame_start,
    input  logic        game_over,
    input  logic        pixel_valid,
    input  logic [9:0]  DrawX,
    input  logic [9:0]  DrawY,
    input  logic [23:0] bg_rgb,
    output logic [18:0] rom_addr,
    input  logic [23:0] rom_data,
    output logic [23:0] out_rgb,
    output logic        out_valid,
    output logic        overlay_active
);

    // -------------------------------------------------------------------------
    // Constants
    // -------------------------------------------------------------------------
    localparam logic [1:0] ST_IDLE       = 2'd0;
    localparam logic [1:0] ST_WAIT_FRAME = 2'd1;
    localparam logic [1:0] ST_SHOW       = 2'd2;

    // Rectangle bounds, one bit wider than DrawX/DrawY so ORIGIN+SIZE cannot wrap.
    localparam logic [10:0] X_LO = 11'(ORIGIN_X);
    localparam logic [10:0] X_HI = 11'(ORIGIN_X + SPRITE_W);
    localparam logic [10:0] Y_LO = 11'(ORIGIN_Y);
    localparam logic [10:0] Y_HI = 11'(ORIGIN_Y + SPRITE_H);

    // Address arithmetic operands, all in the 19-bit address width.
    localparam logic [18:0] X_BASE    = 19'(ORIGIN_X);
    localparam logic [18:0] Y_BASE    = 19'(ORIGIN_Y);
    localparam logic [18:0] ROW_PITCH = 19'(SPRITE_W);

    // A parameter set outside the supported range elaborates this marker block,
    // which then shows up by name in the elaborated hierarchy.
    if ((SPRITE_W * SPRITE_H > 8192) || (BLINK_FRAMES < 1) || (BLINK_FRAMES > 63))
    begin : g_param_out_of_range
    end

    // -------------------------------------------------------------------------
    // Overlay FSM
    // -------------------------------------------------------------------------
    logic [1:0] state;
    logic [1:0] state_next;

    // Next-state decode: show/hide only at frame boundaries, abort a pending show at once.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so no
        // path through the case leaves it unassigned and no latch is inferred.
        state_next = state;
        case (state)
            ST_IDLE: begin
                // A rise that coincides with frame_start still waits a full frame.
                if (game_over) state_next = ST_WAIT_FRAME;
            end
            ST_WAIT_FRAME: begin
                if (!game_over)       state_next = ST_IDLE;
                else if (frame_start) state_next = ST_SHOW;
            end
            ST_SHOW: begin
                // Mid-frame deassertion is held off until the frame boundary.
                if (frame_start && !game_over) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge Clk or negedge Reset_n) begin
        // NOTE: clocked state uses non-blocking assignments so every register
        // samples the pre-edge value of every other register.
        if (!Reset_n) state <= ST_IDLE;
        else          state <= state_next;
    end

    assign overlay_active = (state == ST_SHOW);

    // -------------------------------------------------------------------------
    // Visibility (blink)
    // -------------------------------------------------------------------------
    logic visible;

`ifdef GAMEOVER_BLINK_EN
    localparam logic [5:0] BLINK_LAST = 6'(BLINK_FRAMES - 1);

    logic [5:0] frame_cnt;
    logic       show_enter;

    assign show_enter = (state != ST_SHOW) && (state_next == ST_SHOW);

    // Blink phase: visible on SHOW entry, toggles every BLINK_FRAMES frames, cleared on exit.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            frame_cnt <= '0;
            visible   <= 1'b0;
        end else if (show_enter) begin
            frame_cnt <= '0;
            visible   <= 1'b1;
        end else if (state_next != ST_SHOW) begin
            frame_cnt <= '0;
            visible   <= 1'b0;
        end else if (frame_start) begin
            if (frame_cnt == BLINK_LAST) begin
                frame_cnt <= '0;
                visible   <= ~visible;
            end else begin
                frame_cnt <= frame_cnt + 6'd1;
            end
        end
    end
`else
    // Steady overlay: visible for the whole SHOW period.
    assign visible = (state == ST_SHOW);
`endif

    logic show;
    assign show = (state == ST_SHOW) && visible;

    // -------------------------------------------------------------------------
    // Hit test and RAM address (stage 1 combinational)
    // -------------------------------------------------------------------------
    logic [10:0] draw_x_ext;
    logic [10:0] draw_y_ext;
    logic [18:0] off_x;
    logic [18:0] off_y;
    logic        hit;
    logic [18:0] addr_next;

    assign draw_x_ext = {1'b0, DrawX};
    assign draw_y_ext = {1'b0, DrawY};

    // Rectangle hit test and row-major sprite address; address forced to 0 when not hit.
    always_comb begin
        off_x     = {9'd0, DrawX} - X_BASE;
        off_y     = {9'd0, DrawY} - Y_BASE;
        hit       = pixel_valid
                    && (draw_x_ext >= X_LO) && (draw_x_ext < X_HI)
                    && (draw_y_ext >= Y_LO) && (draw_y_ext < Y_HI);
        addr_next = hit ? (off_y * ROW_PITCH + off_x) : '0;
    end

    // -------------------------------------------------------------------------
    // Pipeline
    // -------------------------------------------------------------------------
    logic        hit_d1;
    logic        show_d1;
    logic        valid_d1;
    logic [23:0] bg_rgb_d1;

    logic        hit_d2;
    logic        show_d2;
    logic        valid_d2;
    logic [23:0] bg_rgb_d2;

    // Stage 1: launch the RAM read and capture the pixel's side-band information.
    always_ff @(posedge Clk or negedge Reset_n) begin
        // NOTE: the colour registers are reset along with the control bits so a
        // mid-line reset leaves the whole pipeline in a known, black state.
        if (!Reset_n) begin
            rom_addr  <= '0;
            hit_d1    <= 1'b0;
            show_d1   <= 1'b0;
            valid_d1  <= 1'b0;
            bg_rgb_d1 <= '0;
        end else begin
            rom_addr  <= addr_next;
            hit_d1    <= hit;
            show_d1   <= show;
            valid_d1  <= pixel_valid;
            bg_rgb_d1 <= bg_rgb;
        end
    end

    // Stage 2: side-band bits advance while the RAM registers its read data.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            hit_d2    <= 1'b0;
            show_d2   <= 1'b0;
            valid_d2  <= 1'b0;
            bg_rgb_d2 <= '0;
        end else begin
            hit_d2    <= hit_d1;
            show_d2   <= show_d1;
            valid_d2  <= valid_d1;
            bg_rgb_d2 <= bg_rgb_d1;
        end
    end

    logic sprite_opaque;
    assign sprite_opaque = hit_d2 && show_d2 && (rom_data != 24'h000000);

    // Stage 3: composite the sprite over the background; black is transparent.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            out_rgb   <= '0;
            out_valid <= 1'b0;
        end else begin
            out_rgb   <= sprite_opaque ? rom_data : bg_rgb_d2;
            out_valid <= valid_d2;
        end
    end

endmodule
